// File: rtl/audio_pkg.sv
// Shared audio types and constants for the sample FIFO, mixer and I2S output.
package audio_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int I2S_SLOTS    = 2 * SAMPLE_W_DEF;

    typedef struct packed {
        logic [SAMPLE_W_DEF-1:0] left;
        logic [SAMPLE_W_DEF-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit/word clock generator: BCLK divider, fall tick, slot counter, LRCLK.
module i2s_clk_gen
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int BCLK_DIV = 4,
    localparam int SLOTS   = 2 * SAMPLE_W,
    localparam int CNT_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1,
    localparam int SLOT_W  = $clog2(SLOTS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    output logic              bclk_o,
    output logic              lrclk_o,
    output logic              fall_tick_o,
    output logic [SLOT_W-1:0] slot_o
);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BCLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
    localparam logic [SLOT_W-1:0] SLOT_RGT  = SLOT_W'(SAMPLE_W);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              bclk_q, bclk_d;
    logic              lr_q, lr_d;
    logic              wrap;

    always_comb begin
        wrap        = (cnt_q == CNT_LAST);
        fall_tick_o = enable_i & wrap & bclk_q;
        cnt_d       = cnt_q;
        bclk_d      = bclk_q;
        slot_d      = slot_q;
        lr_d        = lr_q;
        if (!enable_i) begin
            cnt_d  = '0;
            bclk_d = 1'b0;
            slot_d = SLOT_LAST;
            lr_d   = 1'b0;
        end else begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (wrap) bclk_d = ~bclk_q;
            // Slot and word select move together with the BCLK falling edge
            if (fall_tick_o) begin
                slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
                lr_d   = (slot_d >= SLOT_RGT);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
            slot_q <= SLOT_LAST;
            lr_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
            slot_q <= slot_d;
            lr_q   <= lr_d;
        end
    end

    assign bclk_o  = bclk_q;
    assign lrclk_o = lr_q;
    assign slot_o  = slot_q;

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: pops one stereo word per frame from the sample FIFO
// and serializes it MSB first with the one-bit delay after LRCLK.
module i2s_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int BCLK_DIV = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic [2*SAMPLE_W-1:0] fifo_rdata_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    output logic                  bclk_o,
    output logic                  lrclk_o,
    output logic                  sdata_o,
    output logic                  underrun_o,
    input  logic                  underrun_clr_i
);

    localparam int FW     = 2 * SAMPLE_W;
    localparam int SLOT_W = $clog2(FW);

    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(FW - 1);
    localparam logic [SLOT_W-1:0] SLOT_FETCH = SLOT_W'(FW - 2);

    logic              fall_tick;
    logic [SLOT_W-1:0] slot;

    logic [FW-1:0] shadow_q, shadow_d;
    logic [FW-1:0] shift_q, shift_d;
    logic          sdata_q, sdata_d;
    logic          pend_q, pend_d;
    logic          ur_q, ur_d;
    logic          fetch, load, rd_en, ur_evt;

    i2s_clk_gen #(
        .SAMPLE_W (SAMPLE_W),
        .BCLK_DIV (BCLK_DIV)
    ) u_clk_gen (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .enable_i    (enable_i),
        .bclk_o      (bclk_o),
        .lrclk_o     (lrclk_o),
        .fall_tick_o (fall_tick),
        .slot_o      (slot)
    );

    always_comb begin
        fetch    = fall_tick & (slot == SLOT_FETCH);
        load     = fall_tick & (slot == SLOT_LAST);
        rd_en    = fetch & ~fifo_empty_i;
        ur_evt   = fetch & fifo_empty_i;
        shadow_d = shadow_q;
        shift_d  = shift_q;
        sdata_d  = sdata_q;
        pend_d   = rd_en;
        ur_d     = ur_evt | (ur_q & ~underrun_clr_i);
        if (!enable_i) begin
            shadow_d = '0;
            shift_d  = '0;
            sdata_d  = 1'b0;
            pend_d   = 1'b0;
        end else begin
            if (pend_q)      shadow_d = fifo_rdata_i;
            else if (ur_evt) shadow_d = '0;
            // Delay flop gives the one-bit I2S lag behind LRCLK
            if (fall_tick) begin
                sdata_d = shift_q[FW-1];
                shift_d = load ? shadow_q : {shift_q[FW-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
            shift_q  <= '0;
            sdata_q  <= 1'b0;
            pend_q   <= 1'b0;
            ur_q     <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            shift_q  <= shift_d;
            sdata_q  <= sdata_d;
            pend_q   <= pend_d;
            ur_q     <= ur_d;
        end
    end

    assign fifo_rd_en_o = rd_en;
    assign sdata_o      = sdata_q;
    assign underrun_o   = ur_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: frame-level reference model plus directed scenarios.
module tb_i2s_tx;

    localparam int SW  = 16;
    localparam int DIV = 2;
    localparam int NS  = 2 * SW;
    localparam int FRC = 2 * DIV * NS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        empty = 1'b1;
    logic [31:0] rdata = '0;
    logic        rd_en, bclk, lrclk, sdata, underrun;

    i2s_tx #(
        .SAMPLE_W (SW),
        .BCLK_DIV (DIV)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (en),
        .fifo_rdata_i   (rdata),
        .fifo_empty_i   (empty),
        .fifo_rd_en_o   (rd_en),
        .bclk_o         (bclk),
        .lrclk_o        (lrclk),
        .sdata_o        (sdata),
        .underrun_o     (underrun),
        .underrun_clr_i (clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] fq[$];
    logic [31:0] xq[$];
    logic [31:0] fr[$];
    bit          bits[$];
    int          m_t = 0;
    logic        m_ur = 1'b0;
    logic        s_en, s_rst, s_clr, s_empty, s_rd, s_fetch;
    logic        prev_b = 1'b0;
    bit          seen_fall = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input int f,
                              input logic [31:0] exp);
        logic [31:0] w;
        w = '0;
        checks++;
        if (bits.size() < 32 * f + 33) begin
            errors++;
            $display("FAIL %s: got %0d bits expected at least %0d", name,
                     bits.size(), 32 * f + 33);
        end else begin
            for (int i = 0; i < 32; i++) w[31-i] = bits[32*f+1+i];
            if (w !== exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", name, w, exp);
            end
        end
    endtask

    task automatic push(input logic [31:0] w);
        fq.push_back(w);
        xq.push_back(w);
        empty = 1'b0;
    endtask

    // Reference: t enabled clocks give bclk = (t/DIV)%2 and n = t/(2*DIV) falls
    always @(negedge clk) begin
        int n, k, f;
        logic [31:0] w;
        logic e_b, e_l, e_s, e_r;
        n   = m_t / (2 * DIV);
        e_b = ((m_t / DIV) % 2) == 1;
        e_l = 1'b0;
        e_s = 1'b0;
        if (n > 0) begin
            k   = (n - 1) % NS;
            f   = (n - 1) / NS;
            e_l = (k >= SW);
            if (k == 0) begin
                w   = (f > 0 && f - 1 < fr.size()) ? fr[f-1] : '0;
                e_s = w[0];
            end else begin
                w   = (f < fr.size()) ? fr[f] : '0;
                e_s = w[NS-k];
            end
        end
        s_fetch = rst_n && en && ((m_t + 1) % (2 * DIV) == 0)
                  && ((((m_t + 1) / (2 * DIV)) - 1) % NS == NS - 1);
        e_r = s_fetch && !empty;
        chk("bclk", {31'b0, bclk}, {31'b0, e_b});
        chk("lrclk", {31'b0, lrclk}, {31'b0, e_l});
        chk("sdata", {31'b0, sdata}, {31'b0, e_s});
        chk("rd_en", {31'b0, rd_en}, {31'b0, e_r});
        chk("underrun", {31'b0, underrun}, {31'b0, m_ur});
        if (m_t == 0) begin
            bits.delete();
            seen_fall = 0;
        end else begin
            if (prev_b && !bclk) seen_fall = 1;
            if (!prev_b && bclk && seen_fall) bits.push_back(sdata);
        end
        prev_b  = bclk;
        s_en    = en;
        s_rst   = rst_n;
        s_clr   = clr;
        s_empty = empty;
        s_rd    = rd_en;
    end

    // FIFO environment and model state step after each rising edge
    always begin
        @(posedge clk);
        #1;
        if (s_rd && fq.size() > 0) rdata = fq.pop_front();
        if (!s_rst) begin
            m_t  = 0;
            m_ur = 1'b0;
            fr.delete();
            fr.push_back('0);
        end else if (!s_en) begin
            m_t = 0;
            fr.delete();
            fr.push_back('0);
            if (s_clr) m_ur = 1'b0;
        end else begin
            if (s_fetch && !s_empty) begin
                fr.push_back(xq.size() > 0 ? xq.pop_front() : 32'h0);
            end else if (s_fetch) begin
                fr.push_back('0);
            end
            if (s_fetch && s_empty) m_ur = 1'b1;
            else if (s_clr)         m_ur = 1'b0;
            m_t++;
        end
        empty = (fq.size() == 0);
    end

    task automatic find_rd(input string name, output int idx, output int per);
        int r1, r2;
        logic pb;
        idx = -1;
        r1  = -1;
        r2  = -1;
        pb  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!pb && bclk) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
            pb = bclk;
            if (rd_en) begin
                idx = i;
                break;
            end
        end
        per = r2 - r1;
        if (idx < 0) begin
            errors++;
            $display("FAIL %s: no rd_en within 400 cycles", name);
        end
    endtask

    task automatic wait_t(input int target);
        for (int i = 0; i < 600 && m_t < target; i++) begin
            @(posedge clk);
            #2;
        end
        if (m_t < target) begin
            errors++;
            $display("FAIL wait_t: got t=%0d expected %0d", m_t, target);
        end
    endtask

    task automatic wait_fetch_cycle();
        int i;
        for (i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if ((m_t + 1) % FRC == 0) break;
        end
        if (i == 300) begin
            errors++;
            $display("FAIL wait_fetch: got no fetch cycle expected one in 300");
        end
    endtask

    initial begin
        int idx, per, last, pulses;
        en = 1'b1;
        push(32'hA5A5_0F0F);
        push(32'h1234_5678);
        push(32'hDEAD_BEEF);
        push(32'h0F1E_2D3C);
        repeat (4) @(posedge clk);
        #2;
        chk("rst_bclk", {31'b0, bclk}, 32'd0);
        chk("rst_lrclk", {31'b0, lrclk}, 32'd0);
        chk("rst_sdata", {31'b0, sdata}, 32'd0);
        chk("rst_rd_en", {31'b0, rd_en}, 32'd0);
        chk("rst_underrun", {31'b0, underrun}, 32'd0);
        rst_n = 1'b1;

        find_rd("first_rd", idx, per);
        chk("first_rd_idx", idx, 32'd127);
        chk("bclk_period", per, 32'd4);
        pulses = 1;
        last   = 0;
        for (int j = 1; j < 512; j++) begin
            @(negedge clk);
            if (rd_en) begin
                chk("rd_gap", j - last, 32'd128);
                last = j;
                pulses++;
            end
        end
        chk("rd_count", pulses, 32'd4);

        wait_t(800);
        chk("underrun_set", {31'b0, underrun}, 32'd1);
        check_word("frame0", 0, 32'h0000_0000);
        check_word("frame1", 1, 32'hA5A5_0F0F);
        check_word("frame2", 2, 32'h1234_5678);
        check_word("frame3", 3, 32'hDEAD_BEEF);
        check_word("frame4", 4, 32'h0F1E_2D3C);
        check_word("frame5", 5, 32'h0000_0000);

        clr = 1'b1;
        @(posedge clk);
        #2;
        clr = 1'b0;
        chk("underrun_clr", {31'b0, underrun}, 32'd0);
        wait_fetch_cycle();
        clr = 1'b1;
        @(posedge clk);
        #2;
        clr = 1'b0;
        chk("set_wins", {31'b0, underrun}, 32'd1);

        for (int i = 0; i < 200; i++) begin
            if (m_t > 0 && ((m_t / (2 * DIV)) - 1) % NS == 9) break;
            @(posedge clk);
            #2;
        end
        en = 1'b0;
        @(posedge clk);
        #2;
        chk("dis_bclk", {31'b0, bclk}, 32'd0);
        chk("dis_lrclk", {31'b0, lrclk}, 32'd0);
        chk("dis_sdata", {31'b0, sdata}, 32'd0);
        chk("dis_rd_en", {31'b0, rd_en}, 32'd0);
        chk("dis_underrun", {31'b0, underrun}, 32'd1);
        push(32'hC3C3_3C3C);
        repeat (3) @(posedge clk);
        #2;
        en = 1'b1;
        find_rd("reen_rd", idx, per);
        chk("reen_rd_idx", idx, 32'd127);
        wait_t(270);
        check_word("reen_frame0", 0, 32'h0000_0000);
        check_word("reen_frame1", 1, 32'hC3C3_3C3C);

        push(32'h1111_2222);
        push(32'h3333_4444);
        wait_fetch_cycle();
        @(posedge clk);
        #2;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        en = 1'b1;
        find_rd("lost_rd", idx, per);
        chk("lost_rd_idx", idx, 32'd127);
        wait_t(270);
        check_word("lost_frame0", 0, 32'h0000_0000);
        check_word("lost_frame1", 1, 32'h3333_4444);
        chk("fifo_drained", fq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
